// File: rtl/sram_1r1w_param_if.sv
// Bus bundle for the parameterised 1R1W SRAM: write port, read port and
// status. The master side drives requests; the slave side is the memory.
interface sram_1r1w_param_if #(
    parameter int WIDTH     = 48,
    parameter int DEPTH     = 128,
    parameter int MASK_GRAN = 8
);
    localparam int NMASK = WIDTH / MASK_GRAN;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             CSB1;
    logic [AW-1:0]    WA1;
    logic [NMASK-1:0] WBM1;
    logic [WIDTH-1:0] I1;
    logic             CSB2;
    logic [AW-1:0]    RA2;
    logic [WIDTH-1:0] O2;
    logic             O2_VALID;
    logic             BUSY;

    modport master (
        output CSB1, WA1, WBM1, I1, CSB2, RA2,
        input  O2, O2_VALID, BUSY
    );

    modport slave (
        input  CSB1, WA1, WBM1, I1, CSB2, RA2,
        output O2, O2_VALID, BUSY
    );
endinterface

// File: rtl/sram_1r1w_param.sv
// Parameterised one-read/one-write synchronous SRAM model with per-lane
// write mask, selectable read-during-write result and a zero-clear engine
// that sweeps the whole array after every reset.
// Optional feature macro: SRAM_OUT_REG_EN adds an output pipeline register
// (read latency 2 instead of 1).
module sram_1r1w_param #(
    parameter int WIDTH     = 48,
    parameter int DEPTH     = 128,
    parameter int MASK_GRAN = 8,
    parameter int RDW_MODE  = 0
) (
    input  logic CE1,
    input  logic RST1,
    sram_1r1w_param_if.slave bus
);
    localparam int NMASK = WIDTH / MASK_GRAN;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    clr_ptr;
    logic             busy;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_in_range, rd_in_range;
    logic             wr_en, rd_en, collide;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] o2_p0;
    logic             vld_p0;

    // Replace the lanes selected by mask with the matching lanes of new_w.
    function automatic logic [WIDTH-1:0] merge_lanes(
        input logic [WIDTH-1:0] old_w,
        input logic [WIDTH-1:0] new_w,
        input logic [NMASK-1:0] mask
    );
        logic [WIDTH-1:0] r;
        r = old_w;
        for (int k = 0; k < NMASK; k++) begin
            if (mask[k]) r[k*MASK_GRAN +: MASK_GRAN] = new_w[k*MASK_GRAN +: MASK_GRAN];
        end
        return r;
    endfunction

    // State register and clear pointer; reset always restarts the sweep at 0.
    always_ff @(posedge CE1 or posedge RST1) begin
        if (RST1) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR && clr_ptr != LAST_PTR) clr_ptr <= clr_ptr + 1'b1;
        end
    end

    // Next state: leave CLEAR on the edge that zeroes the last word.
    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_ptr == LAST_PTR) state_nxt = READY;
    end

    // Outputs of the FSM: requests are blocked while the sweep runs.
    always_comb begin
        busy = (state == CLEAR);
    end

    assign bus.BUSY = busy;

    // Address decode; out-of-range writes are dropped, reads return zero.
    always_comb begin
        wr_in_range = ({1'b0, bus.WA1} < DEPTH_X);
        rd_in_range = ({1'b0, bus.RA2} < DEPTH_X);
        wr_en       = !busy && !bus.CSB1 && wr_in_range;
        rd_en       = !busy && !bus.CSB2;
        collide     = wr_en && rd_in_range && !bus.CSB2 && (bus.WA1 == bus.RA2);
    end

    // Read word, with the same-edge write forwarded when new-data mode is chosen.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) rd_word = mem[bus.RA2];
        if (RDW_MODE != 0 && collide) rd_word = merge_lanes(rd_word, bus.I1, bus.WBM1);
    end

    // Array update: zero sweep during CLEAR, masked write otherwise.
    always_ff @(posedge CE1) begin
        if (busy) mem[clr_ptr] <= '0;
        else if (wr_en) mem[bus.WA1] <= merge_lanes(mem[bus.WA1], bus.I1, bus.WBM1);
    end

    // ---- stage p0: read capture on the issue edge ----
    always_ff @(posedge CE1 or posedge RST1) begin
        if (RST1) begin
            o2_p0  <= '0;
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= rd_en;
            if (rd_en) o2_p0 <= rd_word;
        end
    end

`ifdef SRAM_OUT_REG_EN
    logic [WIDTH-1:0] o2_p1;
    logic             vld_p1;

    // ---- stage p1: optional output register, data held between reads ----
    always_ff @(posedge CE1 or posedge RST1) begin
        if (RST1) begin
            o2_p1  <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) o2_p1 <= o2_p0;
        end
    end

    assign bus.O2       = o2_p1;
    assign bus.O2_VALID = vld_p1;
`else
    assign bus.O2       = o2_p0;
    assign bus.O2_VALID = vld_p0;
`endif
endmodule

// File: tb/tb_sram_1r1w_param.sv
// Directed bench for sram_1r1w_param: instance A (128 words, old-data
// read-during-write) and instance B (100 words, new-data read-during-write)
// receive the same stimulus; read results are checked through queues.
module tb_sram_1r1w_param;
`ifdef SRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [47:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   ca, cb;

    sram_1r1w_param_if #(.WIDTH(48), .DEPTH(128), .MASK_GRAN(8)) ifa ();
    sram_1r1w_param_if #(.WIDTH(48), .DEPTH(100), .MASK_GRAN(8)) ifb ();

    sram_1r1w_param #(.WIDTH(48), .DEPTH(128), .MASK_GRAN(8), .RDW_MODE(0)) dut_a (
        .CE1(clk), .RST1(rst), .bus(ifa.slave)
    );
    sram_1r1w_param #(.WIDTH(48), .DEPTH(100), .MASK_GRAN(8), .RDW_MODE(1)) dut_b (
        .CE1(clk), .RST1(rst), .bus(ifb.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: each valid pulse must match the queue head in time and data.
    always @(negedge clk) begin
        if (!rst) begin
            bit   ev;
            exp_t e;
            ev = (qa.size() > 0) && (qa[0].cyc == cyc);
            if (ifa.O2_VALID || ev) chk("a_vld", 64'(ifa.O2_VALID), 64'(ev));
            if (ev) begin
                e = qa.pop_front();
                if (ifa.O2_VALID) chk("a_data", 64'(ifa.O2), 64'(e.data));
            end
            ev = (qb.size() > 0) && (qb[0].cyc == cyc);
            if (ifb.O2_VALID || ev) chk("b_vld", 64'(ifb.O2_VALID), 64'(ev));
            if (ev) begin
                e = qb.pop_front();
                if (ifb.O2_VALID) chk("b_data", 64'(ifb.O2), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ifa.CSB1 = 1'b1; ifa.CSB2 = 1'b1;
        ifb.CSB1 = 1'b1; ifb.CSB2 = 1'b1;
    endtask

    // One cycle of stimulus on both instances, optional write and read.
    task automatic op(input bit w, input logic [6:0] wa, input logic [47:0] wd,
                      input logic [5:0] wm, input bit r, input logic [6:0] ra,
                      input logic [47:0] ea, input logic [47:0] eb);
        ifa.CSB1 = !w; ifa.WA1 = wa; ifa.I1 = wd; ifa.WBM1 = wm;
        ifb.CSB1 = !w; ifb.WA1 = wa; ifb.I1 = wd; ifb.WBM1 = wm;
        ifa.CSB2 = !r; ifa.RA2 = ra;
        ifb.CSB2 = !r; ifb.RA2 = ra;
        if (r) begin
            qa.push_back('{ea, cyc + LAT});
            qb.push_back('{eb, cyc + LAT});
        end
        tick();
        idle_all();
    endtask

    // Count edges until each BUSY falls; ports are idled the moment it does.
    task automatic count_clear(output int na, output int nb);
        int  cnt;
        bit  da, db;
        cnt = 0; da = 0; db = 0; na = 0; nb = 0;
        while (!(da && db) && cnt < 400) begin
            tick();
            cnt++;
            if (!da && !ifa.BUSY) begin na = cnt; da = 1; ifa.CSB1 = 1'b1; ifa.CSB2 = 1'b1; end
            if (!db && !ifb.BUSY) begin nb = cnt; db = 1; ifb.CSB1 = 1'b1; ifb.CSB2 = 1'b1; end
        end
    endtask

    initial begin
        idle_all();
        ifa.WA1 = '0; ifa.RA2 = '0; ifa.I1 = '0; ifa.WBM1 = '0;
        ifb.WA1 = '0; ifb.RA2 = '0; ifb.I1 = '0; ifb.WBM1 = '0;
        repeat (3) tick();
        chk("rst_o2_a", 64'(ifa.O2), 64'h0);
        chk("rst_vld_a", 64'(ifa.O2_VALID), 64'h0);
        chk("rst_busy_a", 64'(ifa.BUSY), 64'h1);
        chk("rst_busy_b", 64'(ifb.BUSY), 64'h1);

        // Requests held active through the sweep must be ignored.
        ifa.CSB1 = 1'b0; ifa.WA1 = 7'd7; ifa.I1 = '1; ifa.WBM1 = '1; ifa.CSB2 = 1'b0; ifa.RA2 = 7'd5;
        ifb.CSB1 = 1'b0; ifb.WA1 = 7'd7; ifb.I1 = '1; ifb.WBM1 = '1; ifb.CSB2 = 1'b0; ifb.RA2 = 7'd5;
        rst = 1'b0;
        count_clear(ca, cb);
        chk("clear_len_a", 64'(ca), 64'd128);
        chk("clear_len_b", 64'(cb), 64'd100);

        // Cleared contents
        op(0, 0, 0, 0, 1, 7'd5, 48'h0, 48'h0);
        op(0, 0, 0, 0, 1, 7'd7, 48'h0, 48'h0);

        // Full write then read back
        op(1, 7'd3, 48'hAABBCCDDEEFF, 6'b111111, 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 7'd3, 48'hAABBCCDDEEFF, 48'hAABBCCDDEEFF);

        // Partial lane write
        op(1, 7'd3, 48'h112233445566, 6'b000101, 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 7'd3, 48'hAABBCC44EE66, 48'hAABBCC44EE66);

        // Same-edge collision: old data on A, merged new data on B
        op(1, 7'd3, 48'h0000000000FF, 6'b000001, 1, 7'd3, 48'hAABBCC44EE66, 48'hAABBCC44EEFF);
        op(0, 0, 0, 0, 1, 7'd3, 48'hAABBCC44EEFF, 48'hAABBCC44EEFF);

        // Independent write and read in one cycle, then zero mask write
        op(1, 7'd10, 48'h0123456789AB, 6'b111111, 1, 7'd3, 48'hAABBCC44EEFF, 48'hAABBCC44EEFF);
        op(1, 7'd10, 48'hFFFFFFFFFFFF, 6'b000000, 1, 7'd10, 48'h0123456789AB, 48'h0123456789AB);
        op(0, 0, 0, 0, 1, 7'd10, 48'h0123456789AB, 48'h0123456789AB);

        // Back-to-back reads, then O2 holds with no valid
        op(0, 0, 0, 0, 1, 7'd3, 48'hAABBCC44EEFF, 48'hAABBCC44EEFF);
        op(0, 0, 0, 0, 1, 7'd5, 48'h0, 48'h0);
        op(0, 0, 0, 0, 1, 7'd10, 48'h0123456789AB, 48'h0123456789AB);
        repeat (LAT + 2) tick();
        chk("hold_o2_a", 64'(ifa.O2), 64'h0123456789AB);
        chk("hold_vld_a", 64'(ifa.O2_VALID), 64'h0);
        chk("hold_o2_b", 64'(ifb.O2), 64'h0123456789AB);

        // Address 120: in range on A, out of range on B (dropped, reads zero)
        op(1, 7'd120, 48'hFFFFFFFFFFFF, 6'b111111, 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 7'd120, 48'hFFFFFFFFFFFF, 48'h0);
        op(0, 0, 0, 0, 1, 7'd99, 48'h0, 48'h0);
        op(0, 0, 0, 0, 1, 7'd20, 48'h0, 48'h0);
        repeat (LAT + 2) tick();

        // Reset with a read in flight
        ifa.CSB2 = 1'b0; ifa.RA2 = 7'd3;
        ifb.CSB2 = 1'b0; ifb.RA2 = 7'd3;
        tick();
        idle_all();
        rst = 1'b1;
        qa.delete();
        qb.delete();
        #1;
        chk("rstrd_o2_a", 64'(ifa.O2), 64'h0);
        chk("rstrd_vld_a", 64'(ifa.O2_VALID), 64'h0);
        chk("rstrd_o2_b", 64'(ifb.O2), 64'h0);
        chk("rstrd_vld_b", 64'(ifb.O2_VALID), 64'h0);
        chk("rstrd_busy_a", 64'(ifa.BUSY), 64'h1);
        repeat (2) tick();
        rst = 1'b0;

        // Reset again in the middle of the sweep
        repeat (60) tick();
        chk("midclear_busy_a", 64'(ifa.BUSY), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_clear(ca, cb);
        chk("reclear_len_a", 64'(ca), 64'd128);
        chk("reclear_len_b", 64'(cb), 64'd100);

        // Earlier contents are gone
        op(0, 0, 0, 0, 1, 7'd3, 48'h0, 48'h0);
        op(0, 0, 0, 0, 1, 7'd10, 48'h0, 48'h0);
        op(0, 0, 0, 0, 1, 7'd120, 48'h0, 48'h0);
        repeat (LAT + 3) tick();
        chk("drain_a", 64'(qa.size()), 64'h0);
        chk("drain_b", 64'(qb.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sram_1r1w_param.md
Name: sram_1r1w_param

Overview:
Parametrised behavioural model of a one-read/one-write synchronous SRAM macro, generalising the fixed 128x48 single-port generated RAMs.
- Adds independent read and write ports, configurable depth/width/mask granularity and selectable read-during-write semantics.
- Adds a reset-triggered zero-clear engine.
- Sits in the generated-RAM library and is instantiated by the RAM generator in place of fixed-size macros.

Parameters:
WIDTH, 48, data word width in bits; must be a multiple of MASK_GRAN
DEPTH, 128, number of words; need not be a power of two
MASK_GRAN, 8, bits per write-mask lane; NMASK = WIDTH/MASK_GRAN
RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new data (merged per lane)

Ports:
CE1  input  1  clock, rising edge
RST1  input  1  asynchronous active-high reset
CSB1  input  1  write-port select, active low
WA1  input  clog2(DEPTH)  write address
WBM1  input  NMASK  write lane mask, bit k enables bits [k*MASK_GRAN +: MASK_GRAN]
I1  input  WIDTH  write data
CSB2  input  1  read-port select, active low
RA2  input  clog2(DEPTH)  read address
O2  output  WIDTH  read data, held between reads
O2_VALID  output  1  one-cycle pulse marking new O2 data
BUSY  output  1  high while the clear engine runs; requests are ignored

Behaviour:
- Reset (RST1 high, asynchronous):
  - O2 = 0, O2_VALID = 0, BUSY = 1, state = CLEAR, clear pointer = 0.
  - Any in-flight read is discarded.
- State CLEAR:
  - Each cycle writes zero to memory[ptr] and increments ptr.
  - On the cycle ptr == DEPTH-1, the last word is written and the state goes to READY.
  - BUSY falls on the following edge: exactly DEPTH cycles after RST1 deasserts.
  - CSB1 and CSB2 are ignored; O2_VALID stays 0.
- State READY:
  - Write: on an edge with CSB1 = 0, each lane with WBM1[k] = 1 is written from I1. Lanes with WBM1[k] = 0 keep their value. WBM1 all zero means no change.
  - Read: on an edge with CSB2 = 0, O2 gets the word at RA2 and O2_VALID = 1 for one cycle (latency 1). Without a read, O2 holds its value and O2_VALID = 0.
  - Reads and writes are fully independent in the same cycle.
- Collision (CSB1 = CSB2 = 0 and WA1 == RA2 on the same edge):
  - RDW_MODE = 0: O2 = memory contents before the write.
  - RDW_MODE = 1: O2 = I1 on masked lanes, old data on unmasked lanes.
  - Memory is written in both modes.
- Out-of-range address (>= DEPTH, possible only when DEPTH is not a power of two):
  - Write is dropped.
  - Read returns all zeros with O2_VALID = 1.
- Back-to-back reads give one O2 update per cycle; there is no throughput bubble.
- Reset asserted mid-clear restarts the clear from address 0.
- Reset asserted in READY does not preserve memory: the full clear re-runs.

Optional Feature:
SRAM_OUT_REG_EN
- Defined: adds an output pipeline register. Read latency becomes 2, and O2_VALID is delayed with the data.
  - The collision decision is still made on the issue edge, using the write of that same edge.
  - Reset clears both stages.
  - Back-to-back throughput remains 1 per cycle.
- Undefined: read latency is 1 as described above.

Test Plan:
1. Release RST1 (WIDTH=48, DEPTH=128, MASK_GRAN=8) -> BUSY high exactly 128 cycles. Then read RA2=5 -> O2=0x000000000000, O2_VALID pulse 1 cycle later.
2. Write WA1=3, I1=0xAABBCCDDEEFF, WBM1=6'b111111; next cycle read RA2=3 -> O2=0xAABBCCDDEEFF at latency 1 (2 with SRAM_OUT_REG_EN).
3. Then write WA1=3, I1=0x112233445566, WBM1=6'b000101; read RA2=3 -> O2=0xAABBCC44EE66.
4. Same-edge write WA1=RA2=3, I1=0x0000000000FF, WBM1=6'b000001, with prior content 0xAABBCC44EE66:
   - RDW_MODE=0 -> O2=0xAABBCC44EE66.
   - RDW_MODE=1 -> O2=0xAABBCC44EEFF.
   - The subsequent read returns 0xAABBCC44EEFF in both modes.
5. Assert RST1 during clear cycle 60, then during a pending read -> O2=0 and O2_VALID=0 immediately; BUSY high a fresh 128 cycles; earlier data reads back as 0.
6. DEPTH=100: write WA1=120 with 0xFFFFFFFFFFFF, then read RA2=120 -> O2=0 with O2_VALID=1; read RA2=99 -> 0 (no aliasing).
